dbpsk_symbol_demod: RTL and testbench

Downstream consumer of the Barker matched-filter despreader in the 802.11b 1 Mbps receive chain. It takes the 32-bit signed I/Q correlator stream (SPS samples per symbol), finds the correlation-peak sample phase during an acquisition window, then decimates to one sample per symbol and performs DBPSK differential detection. It emits one hard bit per symbol to the descrambler.

---
 rtl/dsss_pkg.sv | 20 ++
 rtl/dbpsk_slicer.sv | 31 +++
 rtl/dbpsk_symbol_demod.sv | 174 +++++++++++++++++
 tb/tb_dbpsk_symbol_demod.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsss_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dsss_pkg : shared constants and FSM state type for the 1 Mbps DSSS receive path
// rev 1.0
// ---------------------------------------------------------------------------
package dsss_pkg;

  localparam int SPS_DEFAULT  = 20;
  localparam int IN_W_DEFAULT = 32;
  localparam int METRIC_SHIFT = 8;
  localparam int TRUNC_SHIFT  = 16;
  localparam int P_W          = 16;

  typedef enum logic [0:0] {
    ACQ   = 1'b0,
    TRACK = 1'b1
  } demod_state_e;

endpackage
`default_nettype wire

// File: rtl/dbpsk_slicer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dbpsk_slicer : sign of Re{cur * conj(ref)}, purely combinational
// rev 1.0
// ---------------------------------------------------------------------------
module dbpsk_slicer
  import dsss_pkg::*;
(
  input  logic signed [P_W-1:0] cur_re,
  input  logic signed [P_W-1:0] cur_im,
  input  logic signed [P_W-1:0] ref_re,
  input  logic signed [P_W-1:0] ref_im,
  output logic                  neg
);

  localparam logic signed [2*P_W:0] ZERO = '0;

  logic signed [2*P_W-1:0] prod_re;
  logic signed [2*P_W-1:0] prod_im;
  logic signed [2*P_W:0]   dot;

  always_comb begin
    prod_re = (2*P_W)'(cur_re) * (2*P_W)'(ref_re);
    prod_im = (2*P_W)'(cur_im) * (2*P_W)'(ref_im);
    // one guard bit: two full-scale products can reach 2^31
    dot     = {prod_re[2*P_W-1], prod_re} + {prod_im[2*P_W-1], prod_im};
    neg     = (dot < ZERO);
  end

endmodule
`default_nettype wire

// File: rtl/dbpsk_symbol_demod.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dbpsk_symbol_demod : peak-phase acquisition, symbol decimation, DBPSK detection
// rev 1.0
// ---------------------------------------------------------------------------
module dbpsk_symbol_demod
  import dsss_pkg::*;
#(
  parameter int SPS         = SPS_DEFAULT,
  parameter int IN_W        = IN_W_DEFAULT,
  parameter int ACQ_SYMBOLS = 8,
  parameter int PH_W        = $clog2(SPS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IN_W-1:0] despread_sample_i,
  input  logic [IN_W-1:0] despread_sample_q,
  input  logic            despread_sample_valid,
  input  logic            restart,
  output logic            bit_out,
  output logic            bit_valid,
  output logic            locked,
  output logic [PH_W-1:0] peak_phase
);

  localparam int M_W   = IN_W + 1 - METRIC_SHIFT;
  localparam int ACC_W = M_W + $clog2(ACQ_SYMBOLS);
  localparam int SC_W  = (ACQ_SYMBOLS > 1) ? $clog2(ACQ_SYMBOLS) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SPS - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(ACQ_SYMBOLS - 1);

  demod_state_e state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [SC_W-1:0]  sc_q, sc_d;
  logic [ACC_W-1:0] acc_q [0:SPS-1];
  logic [ACC_W-1:0] acc_d [0:SPS-1];
  logic [ACC_W-1:0] best_val_q, best_val_d;
  logic [PH_W-1:0]  best_idx_q, best_idx_d;
  logic [PH_W-1:0]  peak_phase_q, peak_phase_d;
  logic             ref_valid_q, ref_valid_d;
  logic signed [P_W-1:0] ref_re_q, ref_re_d;
  logic signed [P_W-1:0] ref_im_q, ref_im_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;

  logic [IN_W-1:0]  abs_i, abs_q;
  logic [IN_W:0]    mag_sum;
  logic [M_W-1:0]   metric;
  logic [ACC_W-1:0] acc_sum;
  logic signed [IN_W-1:0] s_i, s_q;
  logic signed [P_W-1:0]  cur_re, cur_im;
  logic             slice_neg;
  logic             ph_last, sc_last, acq_done;

  // Magnitude metric: |I|+|Q| needs one extra bit before the shift
  always_comb begin
    abs_i   = despread_sample_i[IN_W-1] ? (~despread_sample_i) + IN_W'(1) : despread_sample_i;
    abs_q   = despread_sample_q[IN_W-1] ? (~despread_sample_q) + IN_W'(1) : despread_sample_q;
    mag_sum = {1'b0, abs_i} + {1'b0, abs_q};
    metric  = M_W'(mag_sum >> METRIC_SHIFT);
    acc_sum = acc_q[ph_q] + ACC_W'(metric);
    s_i     = $signed(despread_sample_i);
    s_q     = $signed(despread_sample_q);
    cur_re  = P_W'(s_i >>> TRUNC_SHIFT);
    cur_im  = P_W'(s_q >>> TRUNC_SHIFT);
    ph_last = (ph_q == PH_LAST);
    sc_last = (sc_q == SC_LAST);
    acq_done = despread_sample_valid && (state_q == ACQ) && ph_last && sc_last;
  end

  dbpsk_slicer u_slicer (
    .cur_re (cur_re),
    .cur_im (cur_im),
    .ref_re (ref_re_q),
    .ref_im (ref_im_q),
    .neg    (slice_neg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ACQ;
      ph_q         <= '0;
      sc_q         <= '0;
      for (int k = 0; k < SPS; k++) acc_q[k] <= '0;
      best_val_q   <= '0;
      best_idx_q   <= '0;
      peak_phase_q <= '0;
      ref_valid_q  <= 1'b0;
      ref_re_q     <= '0;
      ref_im_q     <= '0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      sc_q         <= sc_d;
      for (int k = 0; k < SPS; k++) acc_q[k] <= acc_d[k];
      best_val_q   <= best_val_d;
      best_idx_q   <= best_idx_d;
      peak_phase_q <= peak_phase_d;
      ref_valid_q  <= ref_valid_d;
      ref_re_q     <= ref_re_d;
      ref_im_q     <= ref_im_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = ACQ;
    end else if (acq_done) begin
      state_d = TRACK;
    end
  end

  always_comb begin
    for (int k = 0; k < SPS; k++) acc_d[k] = acc_q[k];
    ph_d         = ph_q;
    sc_d         = sc_q;
    best_val_d   = best_val_q;
    best_idx_d   = best_idx_q;
    peak_phase_d = peak_phase_q;
    ref_valid_d  = ref_valid_q;
    ref_re_d     = ref_re_q;
    ref_im_d     = ref_im_q;
    bit_out_d    = bit_out_q;
    bit_valid_d  = 1'b0;

    if (restart) begin
      // restart wins over a coincident sample, which is dropped
      for (int k = 0; k < SPS; k++) acc_d[k] = '0;
      ph_d        = '0;
      sc_d        = '0;
      best_val_d  = '0;
      best_idx_d  = '0;
      ref_valid_d = 1'b0;
    end else if (despread_sample_valid) begin
      ph_d = ph_last ? '0 : ph_q + PH_W'(1);
      if (state_q == ACQ) begin
        acc_d[ph_q] = acc_sum;
        if (ph_last && !sc_last) begin
          sc_d = sc_q + SC_W'(1);
        end
        // strict compare keeps the lowest phase on ties
        if (sc_last && (acc_sum > best_val_q)) begin
          best_val_d = acc_sum;
          best_idx_d = ph_q;
        end
        if (ph_last && sc_last) begin
          peak_phase_d = best_idx_d;
        end
      end else if (ph_q == peak_phase_q) begin
        ref_re_d    = cur_re;
        ref_im_d    = cur_im;
        ref_valid_d = 1'b1;
        if (ref_valid_q) begin
          bit_valid_d = 1'b1;
          bit_out_d   = slice_neg;
        end
      end
    end
  end

  always_comb begin
    locked     = (state_q == TRACK);
    bit_out    = bit_out_q;
    bit_valid  = bit_valid_q;
    peak_phase = peak_phase_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_dbpsk_symbol_demod.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dbpsk_symbol_demod : randomized scenarios against a sample-count reference model
// rev 1.0
// ---------------------------------------------------------------------------
module tb_dbpsk_symbol_demod;

  localparam int SPS  = 20;
  localparam int IN_W = 32;
  localparam int ACQ  = 8;
  localparam int PH_W = 5;
  localparam int AMP  = 1000000;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [IN_W-1:0] si = '0;
  logic [IN_W-1:0] sq = '0;
  logic            valid = 1'b0;
  logic            restart = 1'b0;
  logic            bit_out, bit_valid, locked;
  logic [PH_W-1:0] peak_phase;

  always #5 clk = ~clk;

  dbpsk_symbol_demod #(.SPS(SPS), .IN_W(IN_W), .ACQ_SYMBOLS(ACQ), .PH_W(PH_W)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .despread_sample_i     (si),
    .despread_sample_q     (sq),
    .despread_sample_valid (valid),
    .restart               (restart),
    .bit_out               (bit_out),
    .bit_valid             (bit_valid),
    .locked                (locked),
    .peak_phase            (peak_phase)
  );

  int tests_run = 0;
  int failures  = 0;

  // reference model: everything derived from the count of valid samples since restart
  longint m_acc [SPS];
  int     m_k;
  int     m_peak;
  bit     m_ref;
  longint m_pi, m_pq;
  bit     exp_bv, exp_bo, exp_locked;

  bit sign_tab [32];
  bit obs_bits [$];
  bit ref_bits [$];
  int lock_at;

  task automatic model_clear();
    for (int p = 0; p < SPS; p++) m_acc[p] = 0;
    m_k = 0; m_ref = 0; exp_locked = 0; exp_bv = 0;
  endtask

  task automatic model_sample(input logic [31:0] i, input logic [31:0] q);
    longint ii, qq, ci, cq, a_i, a_q;
    int ph;
    ii = longint'($signed(i));
    qq = longint'($signed(q));
    ph = m_k % SPS;
    exp_bv = 0;
    if (m_k < SPS * ACQ) begin
      a_i = (ii < 0) ? -ii : ii;
      a_q = (qq < 0) ? -qq : qq;
      m_acc[ph] += (a_i + a_q) / 256;
      if (m_k == SPS * ACQ - 1) begin
        m_peak = 0;
        for (int p = 1; p < SPS; p++) if (m_acc[p] > m_acc[m_peak]) m_peak = p;
        exp_locked = 1;
      end
    end else if (ph == m_peak) begin
      ci = longint'(int'($signed(i)) >>> 16);
      cq = longint'(int'($signed(q)) >>> 16);
      if (m_ref) begin
        exp_bv = 1;
        exp_bo = ((ci * m_pi + cq * m_pq) < 0);
      end
      m_ref = 1; m_pi = ci; m_pq = cq;
    end
    m_k++;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] q, input logic rs);
    @(negedge clk);
    valid = v; si = i; sq = q; restart = rs;
    @(posedge clk);
    #1;
    if (rs) model_clear();
    else if (v) model_sample(i, q);
    else exp_bv = 0;
    valid = 1'b0; restart = 1'b0;
  endtask

  task automatic gen_sample(input int kind, input int k, output logic [31:0] i, output logic [31:0] q);
    int ph, sym, a;
    ph = k % SPS; sym = k / SPS;
    a = sign_tab[sym % 32] ? -AMP : AMP;
    i = '0; q = '0;
    case (kind)
      0: if (ph == 7) i = 32'(a);
      1: if (ph == 3 || ph == 12) i = 32'(AMP);
      2: if (ph == 12) i = 32'(a);
      default: begin i = $urandom; q = $urandom; end
    endcase
  endtask

  task automatic play(input int kind, input int n_valid, input int gap, input bit do_restart);
    logic [31:0] i, q;
    int g;
    if (do_restart) begin
      drive(1'b0, '0, '0, 1'b1);
      tests_run++;
      if (locked !== 1'b0 || bit_valid !== 1'b0) begin
        failures++;
        $display("FAIL restart_clear: locked=%b bit_valid=%b, required 0 0", locked, bit_valid);
      end
    end
    lock_at = -1;
    obs_bits.delete();
    for (int k = 0; k < n_valid; k++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int j = 0; j < g; j++) begin
        drive(1'b0, $urandom, $urandom, 1'b0);
        tests_run++;
        if (bit_valid !== 1'b0 || locked !== exp_locked) begin
          failures++;
          $display("FAIL idle k=%0d: bit_valid=%b locked=%b, required 0 %b", k, bit_valid, locked, exp_locked);
        end
      end
      gen_sample(kind, k, i, q);
      drive(1'b1, i, q, 1'b0);
      tests_run++;
      if (locked !== exp_locked) begin
        failures++;
        $display("FAIL locked k=%0d: got %b, required %b", k, locked, exp_locked);
      end
      tests_run++;
      if (bit_valid !== exp_bv) begin
        failures++;
        $display("FAIL bit_valid k=%0d: got %b, required %b", k, bit_valid, exp_bv);
      end
      if (exp_bv) begin
        tests_run++;
        if (bit_out !== exp_bo) begin
          failures++;
          $display("FAIL bit_out k=%0d: got %b, required %b", k, bit_out, exp_bo);
        end
      end
      if (exp_locked) begin
        tests_run++;
        if (peak_phase !== PH_W'(m_peak)) begin
          failures++;
          $display("FAIL peak_phase k=%0d: got %0d, required %0d", k, peak_phase, m_peak);
        end
      end
      if (bit_valid === 1'b1) obs_bits.push_back(bit_out);
      if (locked === 1'b1 && lock_at < 0) lock_at = k + 1;
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      valid = 1'($urandom); si = $urandom; sq = $urandom;
      @(posedge clk);
      #1;
      tests_run++;
      if (bit_out !== 1'b0 || bit_valid !== 1'b0 || locked !== 1'b0 || peak_phase !== '0) begin
        failures++;
        $display("FAIL reset c=%0d: bit_out=%b bit_valid=%b locked=%b peak=%0d, required all 0",
                 c, bit_out, bit_valid, locked, peak_phase);
      end
    end
    @(negedge clk);
    valid = 1'b0; reset = 1'b0;
    model_clear();
  endtask

  task automatic test_lock();
    for (int s = 0; s < 32; s++)
      sign_tab[s] = (s < 8) ? 1'b0 : (s == 9) ? 1'b1 : (s < 12) ? 1'b0 : 1'($urandom);
    play(0, 16 * SPS, 0, 1'b1);
    tests_run++;
    if (lock_at != SPS * ACQ) begin
      failures++;
      $display("FAIL lock_point: got %0d valids, required %0d", lock_at, SPS * ACQ);
    end
    tests_run++;
    if (peak_phase !== 5'd7) begin
      failures++;
      $display("FAIL lock_peak: got %0d, required 7", peak_phase);
    end
    tests_run++;
    if (obs_bits.size() != 7 || obs_bits[0] != 1'b1 || obs_bits[1] != 1'b1 || obs_bits[2] != 1'b0) begin
      failures++;
      $display("FAIL first_bits: count %0d, required 7 starting 1,1,0", obs_bits.size());
    end
    ref_bits = obs_bits;
  endtask

  task automatic test_gaps();
    bit same;
    play(0, 16 * SPS, 2, 1'b1);
    tests_run++;
    if (lock_at != SPS * ACQ) begin
      failures++;
      $display("FAIL gap_lock_point: got %0d valids, required %0d", lock_at, SPS * ACQ);
    end
    same = (obs_bits.size() == ref_bits.size());
    for (int b = 0; b < obs_bits.size() && same; b++) same = (obs_bits[b] == ref_bits[b]);
    tests_run++;
    if (!same) begin
      failures++;
      $display("FAIL gap_bits: got %0d bits, required the %0d gap-free bits", obs_bits.size(), ref_bits.size());
    end
  endtask

  task automatic test_tie();
    play(1, 9 * SPS, 0, 1'b1);
    tests_run++;
    if (peak_phase !== 5'd3) begin
      failures++;
      $display("FAIL tie_peak: got %0d, required 3", peak_phase);
    end
  endtask

  task automatic test_restart();
    play(0, 11 * SPS + 10, 0, 1'b1);
    drive(1'b1, 32'(AMP), '0, 1'b1);
    tests_run++;
    if (locked !== 1'b0 || bit_valid !== 1'b0) begin
      failures++;
      $display("FAIL restart_mid: locked=%b bit_valid=%b, required 0 0", locked, bit_valid);
    end
    play(2, 12 * SPS, 0, 1'b0);
    tests_run++;
    if (lock_at != SPS * ACQ || peak_phase !== 5'd12) begin
      failures++;
      $display("FAIL relock: lock at %0d peak %0d, required %0d and 12", lock_at, peak_phase, SPS * ACQ);
    end
  endtask

  task automatic test_random();
    play(3, 20 * SPS, -1, 1'b1);
    tests_run++;
    if (lock_at != SPS * ACQ) begin
      failures++;
      $display("FAIL random_lock_point: got %0d valids, required %0d", lock_at, SPS * ACQ);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_gaps();
    test_tie();
    test_restart();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
`default_nettype wire
